regfile_dump_ctrl: RTL and testbench

Debug-side reader for the 32 x 32-bit integer register file: on a start request it arbitrates for the register file's read port 1, walks every register address in order, and streams each {address, data} pair out over a valid/ready handshake. It sits between the debug/trace logic and the register file, alongside the pipeline's own read-port driver, and holds the read port only while the core grants it.

---
 rtl/regfile_dump_ctrl.sv | 91 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: streams every {address, data} pair of the register file over valid/ready
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a dump when idle / cancel a dump in progress
//   rf_req, rf_gnt     ownership handshake for register-file read port 1
//   rf_addr            read address (decoded, not registered)
//   rf_rd_data         combinational read data for rf_addr
//   out_valid/ready    output beat handshake carrying out_addr, out_data, out_last
//   busy, done         dump in progress / one-cycle completion pulse
module regfile_dump_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rf_req,
    input  logic              rf_gnt,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, REQ, RUN, DRAIN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    state_t state;
    logic [ADDR_W-1:0] cnt;
    logic hs, load;
    assign hs      = out_valid & out_ready;
    // a new register is read only while granted and the output slot is free or draining now
    assign load    = (state == RUN) & rf_gnt & (~out_valid | out_ready);
    assign rf_addr = (state == RUN) ? cnt : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rf_req    <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                rf_req    <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state  <= REQ;
                        cnt    <= '0;
                        rf_req <= 1'b1;
                        busy   <= 1'b1;
                    end
                    REQ: if (rf_gnt) state <= RUN;
                    RUN: if (load) begin
                        out_data  <= rf_rd_data;
                        out_addr  <= cnt;
                        out_valid <= 1'b1;
                        out_last  <= cnt == LAST;
                        cnt       <= cnt + ADDR_W'(1);
                        if (cnt == LAST) begin
                            state  <= DRAIN;
                            rf_req <= 1'b0;
                        end
                    end else if (hs) out_valid <= 1'b0;
                    DRAIN: if (hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: randomized bench for regfile_dump_ctrl against a behavioural model
module tb_regfile_dump_ctrl;
    localparam int N = 32;
    localparam int S_IDLE = 0, S_REQ = 1, S_RUN = 2, S_DRAIN = 3;
    localparam int LIM = 2000;
    logic clk, rst_n, start, abort, rf_req, rf_gnt, out_valid, out_ready, out_last, busy, done;
    logic [4:0] rf_addr, out_addr;
    logic [31:0] rf_rd_data, out_data;
    logic [31:0] regs [N];
    int pass_cnt = 0, total_cnt = 0, cyc = 0;
    int m_st, idx, m_addr;
    logic m_valid, m_last, m_done;
    logic [31:0] m_data;
    int dut_beats, t0, first_v, last_v, done_c, busy_lo;

    regfile_dump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_addr(rf_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    // when the pipeline owns the port the data belongs to someone else
    assign rf_rd_data = rf_gnt ? regs[rf_addr] : (32'hBAD0_0000 | 32'(rf_addr));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total_cnt++;
        if (a !== e) $display("FAIL %s cyc=%0d: got %h expected %h", n, cyc, a, e);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        m_st = S_IDLE; idx = 0; m_addr = 0; m_valid = 0; m_last = 0; m_done = 0; m_data = 0;
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_st != S_IDLE));
        chk("done", 32'(done), 32'(m_done));
        chk("rf_req", 32'(rf_req), 32'(m_st == S_REQ || m_st == S_RUN));
        chk("rf_addr", 32'(rf_addr), (m_st == S_RUN) ? 32'(idx) : 32'd0);
        if (m_valid) begin
            chk("out_addr", 32'(out_addr), 32'(m_addr));
            chk("out_data", out_data, m_data);
            chk("out_last", 32'(out_last), 32'(m_addr == N - 1));
        end
        if (done) chk("done_with_valid", 32'(out_valid), 32'd0);
        if (out_valid && out_ready) dut_beats++;
        if (out_valid && first_v < 0) first_v = cyc - t0;
        if (out_valid && out_last && last_v < 0) last_v = cyc - t0;
        if (done && done_c < 0) done_c = cyc - t0;
        if (!busy && busy_lo < 0 && cyc > t0) busy_lo = cyc - t0;
    endtask

    task automatic step();
        logic hs;
        hs = m_valid && out_ready;
        m_done = 0;
        if (abort && m_st != S_IDLE) begin
            m_st = S_IDLE; m_valid = 0; m_last = 0;
        end else if (m_st == S_IDLE) begin
            if (start && !abort) begin m_st = S_REQ; idx = 0; end
        end else if (m_st == S_REQ) begin
            if (rf_gnt) m_st = S_RUN;
        end else if (m_st == S_RUN) begin
            if (rf_gnt && (!m_valid || out_ready)) begin
                m_valid = 1; m_addr = idx; m_data = regs[idx]; m_last = (idx == N - 1);
                if (idx == N - 1) m_st = S_DRAIN;
                idx++;
            end else if (hs) m_valid = 0;
        end else if (hs) begin
            m_valid = 0; m_done = 1; m_st = S_IDLE;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (rst_n) step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(int gm, int rm);
        rf_gnt = (gm == 0) ? 1'b1 : ($urandom % 4 != 0);
        out_ready = (rm == 0) ? 1'b1 : (rm == 1) ? ~out_ready : 1'($urandom);
    endtask

    task automatic begin_dump(int gm, int rm);
        dut_beats = 0; first_v = -1; last_v = -1; done_c = -1; busy_lo = -1;
        set_in(gm, rm);
        start = 1;
        t0 = cyc;
        tick();
        start = 0;
    endtask

    task automatic finish_dump(int gm, int rm, int restart_at);
        int k;
        k = 0;
        while (m_st != S_IDLE && k < LIM) begin
            set_in(gm, rm);
            start = (k == restart_at);
            tick();
            k++;
        end
        start = 0;
        chk("dump_timeout", 32'(k < LIM), 32'd1);
        chk("beat_count", 32'(dut_beats), 32'd32);
        tick();
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; rf_gnt = 0; out_ready = 0;
        for (int i = 0; i < N; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        model_reset();
        dut_beats = 0; t0 = 0; first_v = -1; last_v = -1; done_c = -1; busy_lo = -1;
        tick();
        tick();
        rst_n = 1;
        chk("reset_out_addr", 32'(out_addr), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        tick();

        begin_dump(0, 0);
        finish_dump(0, 0, -1);
        chk("first_beat_cycle", 32'(first_v), 32'd3);
        chk("last_beat_cycle", 32'(last_v), 32'd34);
        chk("done_cycle", 32'(done_c), 32'd35);
        chk("busy_low_cycle", 32'(busy_lo), 32'd35);

        out_ready = 0;
        begin_dump(0, 1);
        finish_dump(0, 1, -1);

        begin_dump(0, 0);
        for (int k = 0; k < LIM && !(m_valid && m_addr == 10); k++) tick();
        chk("reach_addr10", 32'(m_valid && m_addr == 10), 32'd1);
        rf_gnt = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("gnt_hold_valid", 32'(out_valid), 32'd0);
        chk("gnt_hold_addr", 32'(rf_addr), 32'd11);
        finish_dump(0, 0, -1);

        begin_dump(0, 0);
        for (int k = 0; k < LIM && !(m_valid && m_addr == 15); k++) tick();
        chk("reach_addr15", 32'(m_valid && m_addr == 15), 32'd1);
        out_ready = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_rf_req", 32'(rf_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        begin_dump(0, 0);
        finish_dump(0, 0, -1);
        chk("after_abort_first", 32'(first_v), 32'd3);

        begin_dump(0, 0);
        finish_dump(0, 0, 19);
        tick();
        chk("restart_ignored_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i < N; i++) regs[i] = $urandom;
            begin_dump(2, 2);
            finish_dump(2, 2, (r == 1) ? 7 : -1);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end

        begin_dump(0, 0);
        for (int k = 0; k < 12; k++) tick();
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_rf_req", 32'(rf_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(out_addr), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_rf_addr", 32'(rf_addr), 32'd0);
        model_reset();
        tick();
        rst_n = 1;
        for (int k = 0; k < 3; k++) tick();
        begin_dump(2, 2);
        finish_dump(2, 2, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
